// File: rtl/disp_pkg.sv
// disp_pkg: mode constants, Bayer 2x2 thresholds and helpers for the display colour adapter.
package disp_pkg;
  localparam logic [1:0] DISP_MODE_PAD  = 2'd0;
  localparam logic [1:0] DISP_MODE_REP  = 2'd1;
  localparam logic [1:0] DISP_MODE_MUTE = 2'd2;
  // 2x2 thresholds {0,2,3,1} indexed by {ypar, xpar^fpar}, entry 0 in the LSBs
  localparam logic [7:0] DISP_BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] disp_mode_map(input logic [1:0] m);
    return m == 2'd3 ? DISP_MODE_REP : m;
  endfunction

  function automatic logic [1:0] disp_bayer(input logic [1:0] idx);
    return DISP_BAYER[{idx, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/colour_chan_conv.sv
// colour_chan_conv: combinational BPC_IN->BPC_OUT conversion of one colour channel.
module colour_chan_conv
  import disp_pkg::*;
#(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8
) (
  input  logic [BPC_IN-1:0]  c_i,
  input  logic [1:0]         mode_i,
  input  logic               dith_i,
  input  logic [BPC_IN-1:0]  thr_i,
  output logic [BPC_OUT-1:0] c_o
);
  logic [BPC_OUT-1:0] pad, rep;
  if (BPC_OUT > BPC_IN) begin : g_widen
    logic unused_narrow;
    assign unused_narrow = ^{dith_i, thr_i};
    assign pad = {c_i, {(BPC_OUT-BPC_IN){1'b0}}};
    for (genvar k = 0; k < BPC_OUT; k++) begin : g_rep
      assign rep[BPC_OUT-1-k] = c_i[BPC_IN-1-(k % BPC_IN)];
    end
  end else if (BPC_OUT < BPC_IN) begin : g_narrow
    localparam int D = BPC_IN - BPC_OUT;
    localparam logic [BPC_IN:0] HALF = {{BPC_IN{1'b0}}, 1'b1} << (D-1);
    logic [BPC_IN:0] sum;
    assign pad = c_i[BPC_IN-1 -: BPC_OUT];
    // a carry out of the top bit means the rounded value no longer fits: saturate
    assign sum = {1'b0, c_i} + (dith_i ? {1'b0, thr_i} : HALF);
    assign rep = sum[BPC_IN] ? '1 : sum[BPC_IN-1 -: BPC_OUT];
  end else begin : g_pass
    logic unused_narrow;
    assign unused_narrow = ^{dith_i, thr_i};
    assign pad = c_i;
    assign rep = c_i;
  end
  assign c_o = mode_i == DISP_MODE_MUTE ? '0 : mode_i == DISP_MODE_PAD ? pad : rep;
endmodule

// File: rtl/disp_colour_adapt.sv
// disp_colour_adapt: 2-cycle colour-depth adapter with frame-aligned mode changes.
// Ordered 2x2 dither for mode-1 narrowing is built only with DISP_ADAPT_DITHER_EN defined.
module disp_colour_adapt
  import disp_pkg::*;
#(
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8,
  parameter int CHAN     = 3,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_dither,
  input  logic                    in_de,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic                    in_frame,
  input  logic [CHAN*BPC_IN-1:0]  in_colr,
  output logic                    out_de,
  output logic                    out_hsync,
  output logic                    out_vsync,
  output logic [CHAN*BPC_OUT-1:0] out_colr,
  output logic [1:0]              mode_act
);
  logic [1:0] mode_q, mode_d;
  logic de1_q, hs1_q, vs1_q, dith_en;
  logic [CHAN*BPC_IN-1:0] colr1_q;
  logic [BPC_IN-1:0] thr;
  logic [CHAN*BPC_OUT-1:0] conv, colr_d;
  assign mode_d = in_frame ? disp_mode_map(cfg_mode) : mode_q;
  assign colr_d = de1_q ? conv : '0;
  assign mode_act = mode_q;
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      mode_q <= DISP_MODE_REP;
      {de1_q, out_de} <= '0;
      {hs1_q, vs1_q, out_hsync, out_vsync} <= {4{~SYNC_POL}};
      colr1_q <= '0;
      out_colr <= '0;
    end else begin
      mode_q <= mode_d;
      {de1_q, hs1_q, vs1_q, colr1_q} <= {in_de, in_hsync, in_vsync, in_colr};
      {out_de, out_hsync, out_vsync, out_colr} <= {de1_q, hs1_q, vs1_q, colr_d};
    end
  end
`ifdef DISP_ADAPT_DITHER_EN
  localparam int D = BPC_IN > BPC_OUT ? BPC_IN - BPC_OUT : 0;
  logic dith_q, xpar_q, ypar_q, fpar_q, xc, yc, fc;
  logic [1:0] idx_q;
  // parity of the pixel presented this cycle; de1_q doubles as the previous in_de
  assign xc = (in_de & ~de1_q) ? 1'b0 : xpar_q;
  assign yc = in_frame ? 1'b0 : ypar_q;
  assign fc = fpar_q ^ in_frame;
  assign thr = BPC_IN'((32'(disp_bayer(idx_q)) << D) >> 2);
  assign dith_en = dith_q;
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      {dith_q, xpar_q, ypar_q, fpar_q} <= '0;
      idx_q <= '0;
    end else begin
      dith_q <= in_frame ? cfg_dither : dith_q;
      xpar_q <= in_de ? ~xc : xpar_q;
      ypar_q <= in_frame ? 1'b0 : (~in_de & de1_q) ? ~ypar_q : ypar_q;
      fpar_q <= fc;
      idx_q <= {yc, xc ^ fc};
    end
  end
`else
  logic unused_dither;
  assign unused_dither = cfg_dither;
  assign dith_en = 1'b0;
  assign thr = '0;
`endif
  for (genvar g = 0; g < CHAN; g++) begin : g_chan
    colour_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv (
      .c_i   (colr1_q[g*BPC_IN +: BPC_IN]),
      .mode_i(mode_q),
      .dith_i(dith_en),
      .thr_i (thr),
      .c_o   (conv[g*BPC_OUT +: BPC_OUT])
    );
  end
endmodule

// File: tb/tb_disp_colour_adapt.sv
// tb_disp_colour_adapt: checks a 5->8 and an 8->5 adapter against an arithmetic model plus literal pins.
module tb_disp_colour_adapt;
`ifdef DISP_ADAPT_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] cfg_mode = 2'd1;
  logic cfg_dither = 1'b0, de = 1'b0, hs = 1'b0, vs = 1'b0, fr = 1'b0;
  logic [14:0] ca = '0;
  logic [23:0] cb = '0;
  logic a_de, a_hs, a_vs, b_de, b_hs, b_vs;
  logic [23:0] a_col;
  logic [14:0] b_col;
  logic [1:0] a_mode, b_mode;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  disp_colour_adapt ua (
    .clk_pix(clk), .rst_pix_n(rst_n), .cfg_mode(cfg_mode), .cfg_dither(cfg_dither),
    .in_de(de), .in_hsync(hs), .in_vsync(vs), .in_frame(fr), .in_colr(ca),
    .out_de(a_de), .out_hsync(a_hs), .out_vsync(a_vs), .out_colr(a_col), .mode_act(a_mode));

  disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5)) ub (
    .clk_pix(clk), .rst_pix_n(rst_n), .cfg_mode(cfg_mode), .cfg_dither(cfg_dither),
    .in_de(de), .in_hsync(hs), .in_vsync(vs), .in_frame(fr), .in_colr(cb),
    .out_de(b_de), .out_hsync(b_hs), .out_vsync(b_vs), .out_colr(b_col), .mode_act(b_mode));

  function automatic int cv(int c, int bi, int bo, int m, bit dth, int idx);
    int t, d, r, n;
    if (m == 2) return 0;
    if (bo > bi) begin
      if (m == 0) return c << (bo - bi);
      r = 0;
      n = 0;
      while (n < bo) begin
        r = (r << bi) | c;
        n += bi;
      end
      return r >> (n - bo);
    end
    if (bo == bi) return c;
    d = bi - bo;
    if (m == 0) return c >> d;
    t = idx == 0 ? 0 : idx == 1 ? 2 : idx == 2 ? 3 : 1;
    r = (c + (dth ? (t << d) >> 2 : 1 << (d - 1))) >> d;
    return r > (1 << bo) - 1 ? (1 << bo) - 1 : r;
  endfunction

  function automatic logic [23:0] conv_a(logic [14:0] c, int m);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = 8'(cv(int'(c[k*5 +: 5]), 5, 8, m, 1'b0, 0));
    return r;
  endfunction

  function automatic logic [14:0] conv_b(logic [23:0] c, int m, bit dth, int idx);
    logic [14:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) r[k*5 +: 5] = 5'(cv(int'(c[k*8 +: 8]), 8, 5, m, dth, idx));
    return r;
  endfunction

  // model: integer pixel/line/frame counters and a plain 2-deep delay of expected outputs
  typedef struct packed {logic de, hs, vs; logic [23:0] a; logic [14:0] b;} exp_t;
  exp_t cur, p1, p2;
  int mode_m, nm, x, y, f, xc, yc, fc, idx;
  bit dm, dc, pde;

  always_comb begin
    nm = fr ? ((cfg_mode == 2'd3) ? 1 : int'(cfg_mode)) : mode_m;
    dc = fr ? cfg_dither : dm;
    xc = (de && !pde) ? 0 : x;
    yc = fr ? 0 : y;
    fc = fr ? f + 1 : f;
    idx = ((yc & 1) << 1) | ((xc ^ fc) & 1);
    cur = '0;
    cur.de = de;
    cur.hs = hs;
    cur.vs = vs;
    cur.a = de ? conv_a(ca, nm) : '0;
    cur.b = de ? conv_b(cb, nm, DITH && dc, idx) : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
      mode_m <= 1;
      {x, y, f} <= '0;
      {dm, pde} <= '0;
    end else begin
      p1 <= cur;
      p2 <= p1;
      mode_m <= nm;
      dm <= dc;
      pde <= de;
      x <= de ? xc + 1 : x;
      y <= fr ? 0 : (!de && pde) ? y + 1 : y;
      f <= fc;
    end
  end

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", what, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (en) begin
    chk("model de_a", 32'(a_de), 32'(p2.de));
    chk("model hs_a", 32'(a_hs), 32'(p2.hs));
    chk("model vs_a", 32'(a_vs), 32'(p2.vs));
    chk("model colr_a", 32'(a_col), 32'(p2.a));
    chk("model de_b", 32'(b_de), 32'(p2.de));
    chk("model hs_b", 32'(b_hs), 32'(p2.hs));
    chk("model vs_b", 32'(b_vs), 32'(p2.vs));
    chk("model colr_b", 32'(b_col), 32'(p2.b));
    chk("model mode_a", 32'(a_mode), 32'(mode_m));
    chk("model mode_b", 32'(b_mode), 32'(mode_m));
  end

  task automatic drv(bit d, bit h, bit v, bit fm, logic [14:0] a, logic [23:0] b);
    @(negedge clk);
    #1;
    {de, hs, vs, fr, ca, cb} = {d, h, v, fm, a, b};
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] dexp(int frm, int ln, int px);
    return (DITH && ln == 1 && ((px & 1) != frm)) ? 15'h0421 : 15'h0000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    en = 1'b1;
    #1;
    chk("reset colr_a", 32'(a_col), 32'h0);
    chk("reset de_a", 32'(a_de), 32'h0);
    chk("reset hsync_a", 32'(a_hs), 32'h0);
    chk("reset mode", 32'(a_mode), 32'h1);
    rst_n = 1'b1;
    // mode 1 frame: replicate / round
    drv(1, 0, 0, 1, {5'h1F, 5'h10, 5'h00}, {8'hFF, 8'h04, 8'h03});
    drv(1, 0, 0, 0, {5'h01, 5'h0A, 5'h15}, {8'h07, 8'h80, 8'hFC});
    settle();
    chk("rep 5to8", 32'(a_col), 32'hFF8400);
    chk("round 8to5", 32'(b_col), 32'h7C20);
    for (int i = 0; i < 12; i++)
      drv(i < 8, i == 9 || i == 10, i == 11, 0, 15'($urandom()), 24'($urandom()));
    drv(0, 1, 1, 0, '0, '0);
    drv(0, 0, 0, 0, '0, '0);
    settle();
    chk("hsync delay", 32'(a_hs), 32'h1);
    chk("vsync delay", 32'(b_vs), 32'h1);
    // mode 0 frame: pad / truncate
    cfg_mode = 2'd0;
    drv(1, 0, 0, 1, {5'h1F, 5'h10, 5'h01}, {8'h07, 8'hFF, 8'h08});
    drv(1, 0, 0, 0, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    settle();
    chk("pad 5to8", 32'(a_col), 32'hF88008);
    chk("trunc 8to5", 32'(b_col), 32'h03E1);
    chk("mode latch 0", 32'(a_mode), 32'h0);
    // mute requested mid-frame: no effect until the next frame pulse
    cfg_mode = 2'd2;
    drv(1, 0, 0, 0, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    settle();
    chk("midframe hold", 32'(a_col), 32'hF8F8F8);
    chk("midframe mode", 32'(b_mode), 32'h0);
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 1, 0, 1, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    drv(1, 0, 0, 0, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    settle();
    chk("mute colr_a", 32'(a_col), 32'h0);
    chk("mute colr_b", 32'(b_col), 32'h0);
    chk("mute de", 32'(a_de), 32'h1);
    chk("mute hsync", 32'(a_hs), 32'h1);
    chk("mute mode", 32'(a_mode), 32'h2);
    // mode 3 aliases mode 1; blanked all-ones input must give zero
    cfg_mode = 2'd3;
    drv(0, 0, 0, 1, '1, '1);
    drv(0, 0, 0, 0, '1, '1);
    settle();
    chk("blank colr_a", 32'(a_col), 32'h0);
    chk("blank colr_b", 32'(b_col), 32'h0);
    chk("mode 3 maps 1", 32'(b_mode), 32'h1);
    for (int fm = 0; fm < 4; fm++) begin
      cfg_mode = 2'(fm);
      cfg_dither = fm[0];
      for (int ln = 0; ln < 3; ln++) begin
        for (int px = 0; px < 10; px++)
          drv(1, 0, ln == 0 && px < 2, ln == 0 && px == 0, 15'($urandom()), 24'($urandom()));
        drv(0, 1, 0, 0, 15'($urandom()), 24'($urandom()));
        drv(0, 1, 0, 0, '1, '1);
      end
    end
    // mid-line asynchronous reset
    cfg_mode = 2'd0;
    cfg_dither = 1'b0;
    drv(1, 0, 0, 1, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    drv(1, 0, 0, 0, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    drv(1, 0, 0, 0, {5'h1F, 5'h1F, 5'h1F}, {8'hFF, 8'hFF, 8'hFF});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst de", 32'(a_de), 32'h0);
    chk("async rst colr_a", 32'(a_col), 32'h0);
    chk("async rst colr_b", 32'(b_col), 32'h0);
    chk("async rst mode", 32'(a_mode), 32'h1);
    drv(0, 0, 0, 0, '0, '0);
    drv(0, 0, 0, 0, '0, '0);
    rst_n = 1'b1;
    cfg_mode = 2'd1;
    drv(1, 0, 0, 0, {5'h1F, 5'h10, 5'h00}, {8'hFF, 8'h04, 8'h03});
    settle();
    chk("post rst latency1", 32'(a_de), 32'h0);
    drv(0, 0, 0, 0, '0, '0);
    settle();
    chk("post rst latency2", 32'(a_de), 32'h1);
    chk("post rst colr", 32'(a_col), 32'hFF8400);
    chk("post rst mode", 32'(b_mode), 32'h1);
    // dither pattern on a flat 8'h02 field, two frames
    cfg_dither = 1'b1;
    for (int fi = 0; fi < 2; fi++)
      for (int ln = 0; ln < 2; ln++) begin
        for (int px = 0; px <= 4; px++) begin
          if (px < 4) drv(1, 0, 0, ln == 0 && px == 0, '0, {3{8'h02}});
          else drv(0, 0, 0, 0, '0, '0);
          if (px > 0) begin
            settle();
            chk("dither", 32'(b_col), 32'(dexp(fi, ln, px - 1)));
          end
        end
        drv(0, 0, 0, 0, '0, '0);
      end
    repeat (3) drv(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
